// File: rtl/fifo_round_robin_router_pkg.sv
// Shared constants and FSM encoding for the ingress-to-egress round-robin router.
package fifo_round_robin_router_pkg;
    localparam int DEF_DATA_W = 10;
    localparam int NUM_PORTS  = 4;
    localparam int CLS_W      = 2;   // class field is the top CLS_W bits of a word

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter: scans from ptr upward (mod 4),
// first requester wins. Emits one-hot grant, its index and a valid flag.
module rr_arbiter_4
    import fifo_round_robin_router_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);
    always_comb begin
        logic [1:0] k;
        k     = '0;
        grant = '0;
        idx   = ptr;
        any   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = ptr + 2'(i);
            if (!any && req[k]) begin
                grant[k] = 1'b1;
                idx      = k;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_round_robin_router.sv
// Grants one eligible ingress FIFO per cycle in round-robin order and pushes
// the popped word, one cycle later, into the egress FIFO named by its class bits.
module fifo_round_robin_router
    import fifo_round_robin_router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              empty_3,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic              almost_full_0,
    input  logic              almost_full_1,
    input  logic              almost_full_2,
    input  logic              almost_full_3,
    output logic              pop_0,
    output logic              pop_1,
    output logic              pop_2,
    output logic              pop_3,
    output logic              push_0,
    output logic              push_1,
    output logic              push_2,
    output logic              push_3,
    output logic [DATA_W-1:0] data_out,
    output logic              active,
    output logic [1:0]        grant_idx
);
    logic [NUM_PORTS-1:0]             empty_v, af_v, req, grant, push_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] din;
    logic [1:0]                       ptr, win_idx, win_cls;
    logic [DATA_W-1:0]                win_word;
    logic                             win;
    state_t                           state;

    assign empty_v = {empty_3, empty_2, empty_1, empty_0};
    assign af_v    = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
    assign din     = {data_in_3, data_in_2, data_in_1, data_in_0};

    // A head whose destination is almost full is simply not a requester, so
    // the scan moves past it instead of stalling the other ingress FIFOs.
    always_comb begin
        req = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            req[k] = enable && (state != DRAIN) && !empty_v[k]
                     && !af_v[din[k][DATA_W-1 -: CLS_W]];
    end

    rr_arbiter_4 u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win)
    );

    assign win_word = din[win_idx];
    assign win_cls  = win_word[DATA_W-1 -: CLS_W];

    assign {pop_3, pop_2, pop_1, pop_0}     = reset_L ? grant : '0;
    assign {push_3, push_2, push_1, push_0} = push_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            data_out  <= '0;
            push_q    <= '0;
            active    <= 1'b0;
        end else begin
            push_q <= '0;
            if (win) begin
                data_out        <= win_word;
                push_q[win_cls] <= 1'b1;
                grant_idx       <= win_idx;
                ptr             <= win_idx + 2'd1;
            end
            case (state)
                IDLE: if (win) begin
                    state  <= ACTIVE;
                    active <= 1'b1;
                end
                ACTIVE: begin
                    if (!enable && (|push_q)) begin
                        state  <= DRAIN;
                        active <= 1'b0;
                    end else if (!win && !(|push_q)) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_round_robin_router.sv
// Directed, table-driven bench for fifo_round_robin_router plus an async-reset sequence.
module tb_fifo_round_robin_router;
    localparam int W = 10;

    typedef struct {
        logic         en;
        logic [3:0]   empty;
        logic [3:0]   af;
        logic [W-1:0] d0, d1, d2, d3;
        logic [3:0]   pop;
        logic [3:0]   push;
        logic [W-1:0] dout;
        logic [1:0]   gidx;
        logic         act;
    } vec_t;

    logic         clk, reset_L, enable;
    logic         empty_0, empty_1, empty_2, empty_3;
    logic [W-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic         almost_full_0, almost_full_1, almost_full_2, almost_full_3;
    logic         pop_0, pop_1, pop_2, pop_3;
    logic         push_0, push_1, push_2, push_3;
    logic [W-1:0] data_out;
    logic         active;
    logic [1:0]   grant_idx;
    logic [3:0]   pop_v, push_v;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    fifo_round_robin_router #(.DATA_W(W)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .data_in_2(data_in_2), .data_in_3(data_in_3),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .almost_full_2(almost_full_2), .almost_full_3(almost_full_3),
        .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
        .push_0(push_0), .push_1(push_1), .push_2(push_2), .push_3(push_3),
        .data_out(data_out), .active(active), .grant_idx(grant_idx)
    );

    assign pop_v  = {pop_3, pop_2, pop_1, pop_0};
    assign push_v = {push_3, push_2, push_1, push_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] empty, input logic [3:0] af,
                                input logic [W-1:0] d0, input logic [W-1:0] d1,
                                input logic [W-1:0] d2, input logic [W-1:0] d3,
                                input logic [3:0] pop, input logic [3:0] push,
                                input logic [W-1:0] dout, input logic [1:0] gidx,
                                input logic act);
        vec_t v;
        v.en = en; v.empty = empty; v.af = af;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.pop = pop; v.push = push; v.dout = dout; v.gidx = gidx; v.act = act;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        enable = v.en;
        {empty_3, empty_2, empty_1, empty_0} = v.empty;
        {almost_full_3, almost_full_2, almost_full_1, almost_full_0} = v.af;
        data_in_0 = v.d0; data_in_1 = v.d1; data_in_2 = v.d2; data_in_3 = v.d3;
    endtask

    // Called 1 time unit after a rising edge: pops are checked before the
    // next edge, registered outputs just after it.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #1;
        chk("pop", idx, 32'(pop_v), 32'(v.pop));
        @(posedge clk);
        #1;
        chk("push", idx, 32'(push_v), 32'(v.push));
        chk("data_out", idx, 32'(data_out), 32'(v.dout));
        chk("grant_idx", idx, 32'(grant_idx), 32'(v.gidx));
        chk("active", idx, 32'(active), 32'(v.act));
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".pop"}, 0, 32'(pop_v), 0);
        chk({name, ".push"}, 0, 32'(push_v), 0);
        chk({name, ".data_out"}, 0, 32'(data_out), 0);
        chk({name, ".active"}, 0, 32'(active), 0);
        chk({name, ".grant_idx"}, 0, 32'(grant_idx), 0);
    endtask

    initial begin
        vec_t all4;
        all4 = mk(1, 4'b0000, 4'b0000, 10'h001, 10'h102, 10'h203, 10'h304,
                  4'b0001, 4'b0001, 10'h001, 2'd0, 1);

        // fairness from ptr=0: grants 0,1,2,3,0
        vecs.push_back(all4);
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 10'h001, 10'h102, 10'h203, 10'h304, 4'b0010, 4'b0010, 10'h102, 2'd1, 1));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 10'h001, 10'h102, 10'h203, 10'h304, 4'b0100, 4'b0100, 10'h203, 2'd2, 1));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 10'h001, 10'h102, 10'h203, 10'h304, 4'b1000, 4'b1000, 10'h304, 2'd3, 1));
        vecs.push_back(all4);
        // idle: stays ACTIVE while a push is in flight, then IDLE
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0000, 10'h001, 2'd0, 1));
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0000, 10'h001, 2'd0, 0));
        // single word on ingress 2, class 1
        vecs.push_back(mk(1, 4'b1011, 4'b0000, 10'h000, 10'h000, 10'h105, 10'h000, 4'b0100, 4'b0010, 10'h105, 2'd2, 1));
        // only ingress 3 -> ptr becomes 0
        vecs.push_back(mk(1, 4'b0111, 4'b0000, 10'h000, 10'h000, 10'h000, 10'h3AA, 4'b1000, 4'b1000, 10'h3AA, 2'd3, 1));
        // backpressure: ingress 0 -> class 3 (almost full) skipped, ingress 1 served
        vecs.push_back(mk(1, 4'b1100, 4'b1000, 10'h3C0, 10'h022, 10'h000, 10'h000, 4'b0010, 4'b0001, 10'h022, 2'd1, 1));
        vecs.push_back(mk(1, 4'b1100, 4'b1000, 10'h3C0, 10'h022, 10'h000, 10'h000, 4'b0010, 4'b0001, 10'h022, 2'd1, 1));
        vecs.push_back(mk(1, 4'b1100, 4'b0000, 10'h3C0, 10'h022, 10'h000, 10'h000, 4'b0001, 4'b1000, 10'h3C0, 2'd0, 1));
        // set ptr=3, then wrap: 3 then 0
        vecs.push_back(mk(1, 4'b1011, 4'b0000, 10'h000, 10'h000, 10'h2F0, 10'h000, 4'b0100, 4'b0100, 10'h2F0, 2'd2, 1));
        vecs.push_back(mk(1, 4'b0110, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h3AA, 4'b1000, 4'b1000, 10'h3AA, 2'd3, 1));
        vecs.push_back(mk(1, 4'b0110, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h3AA, 4'b0001, 4'b0001, 10'h011, 2'd0, 1));
        // enable drop with push in flight -> DRAIN (no grant even with enable back) -> IDLE
        vecs.push_back(mk(0, 4'b0110, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h3AA, 4'b0000, 4'b0000, 10'h011, 2'd0, 0));
        vecs.push_back(mk(1, 4'b0110, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h3AA, 4'b0000, 4'b0000, 10'h011, 2'd0, 0));
        vecs.push_back(mk(1, 4'b0110, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h3AA, 4'b1000, 4'b1000, 10'h3AA, 2'd3, 1));
        // every destination almost full: nothing eligible
        vecs.push_back(mk(1, 4'b0000, 4'b1111, 10'h001, 10'h102, 10'h203, 10'h304, 4'b0000, 4'b0000, 10'h3AA, 2'd3, 1));
        vecs.push_back(mk(1, 4'b0000, 4'b1111, 10'h001, 10'h102, 10'h203, 10'h304, 4'b0000, 4'b0000, 10'h3AA, 2'd3, 0));

        // reset with traffic present: pops must stay low
        reset_L = 1'b0;
        drive(all4);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");

        reset_L = 1'b1;
        foreach (vecs[i]) apply(vecs[i], i);

        // async reset between edges during continuous traffic
        apply(all4, 100);
        apply(mk(1, 4'b0000, 4'b0000, 10'h001, 10'h102, 10'h203, 10'h304, 4'b0010, 4'b0010, 10'h102, 2'd1, 1), 101);
        #2;
        reset_L = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        chk_zero("async_reset_hold");
        reset_L = 1'b1;
        apply(all4, 102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
